// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM command port between the ROM download
// path and the Z80 bus. Download bytes go through a 2-entry FIFO. Each grant
// holds the strobes for a fixed slot and then completes in a one-cycle DONE.
module sdram_port_arbiter #(
  parameter int          SLOT_CYCLES = 4,
  parameter logic [24:0] DL_BASE     = 25'h000C000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [13:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_overrun,
  output logic        rom_loaded,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_oe,
  input  logic [7:0]  mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAST_SLOT = 4'(SLOT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        grant_dl_reg, grant_dl_next;
  logic [3:0]  slot_reg, slot_next;

  logic [24:0] mem_addr_reg, mem_addr_next;
  logic [7:0]  mem_din_reg, mem_din_next;
  logic        mem_we_reg, mem_we_next;
  logic        mem_oe_reg, mem_oe_next;
  logic        cpu_ack_reg, cpu_ack_next;
  logic [7:0]  cpu_rdata_reg, cpu_rdata_next;
  logic        busy_reg, busy_next;

  // Download FIFO: two entries, pointer-addressed storage.
  logic [13:0] fifo_addr [2];
  logic [7:0]  fifo_data [2];
  logic        wr_ptr_reg, rd_ptr_reg;
  logic [1:0]  count_reg;
  logic        fifo_pop, fifo_accept;
  logic [13:0] head_addr;
  logic [7:0]  head_data;

  // Status flags
  logic        dl_active_q_reg;
  logic        seen_write_reg;
  logic        dl_overrun_reg;
  logic        rom_loaded_reg;
  logic        dl_rise;

  assign fifo_pop    = (state_reg == DONE) && grant_dl_reg;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign fifo_accept = dl_wr && ((count_reg != 2'd2) || fifo_pop);
  assign head_addr   = fifo_addr[rd_ptr_reg];
  assign head_data   = fifo_data[rd_ptr_reg];
  assign dl_rise     = dl_active && !dl_active_q_reg;

  // FIFO payload storage; contents need no reset since count guards them.
  always_ff @(posedge clk) begin
    if (fifo_accept) begin
      fifo_addr[wr_ptr_reg] <= dl_addr;
      fifo_data[wr_ptr_reg] <= dl_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (fifo_accept) wr_ptr_reg <= ~wr_ptr_reg;
      if (fifo_pop)    rd_ptr_reg <= ~rd_ptr_reg;
      case ({fifo_accept, fifo_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Arbiter state and registered memory/CPU outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      grant_dl_reg  <= 1'b0;
      slot_reg      <= 4'd0;
      mem_addr_reg  <= 25'd0;
      mem_din_reg   <= 8'd0;
      mem_we_reg    <= 1'b0;
      mem_oe_reg    <= 1'b0;
      cpu_ack_reg   <= 1'b0;
      cpu_rdata_reg <= 8'd0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_dl_reg  <= grant_dl_next;
      slot_reg      <= slot_next;
      mem_addr_reg  <= mem_addr_next;
      mem_din_reg   <= mem_din_next;
      mem_we_reg    <= mem_we_next;
      mem_oe_reg    <= mem_oe_next;
      cpu_ack_reg   <= cpu_ack_next;
      cpu_rdata_reg <= cpu_rdata_next;
      busy_reg      <= busy_next;
    end
  end

  // Next-state and output logic: download first, CPU only when no download.
  always_comb begin
    state_next     = state_reg;
    grant_dl_next  = grant_dl_reg;
    slot_next      = slot_reg;
    mem_addr_next  = mem_addr_reg;
    mem_din_next   = mem_din_reg;
    mem_we_next    = mem_we_reg;
    mem_oe_next    = mem_oe_reg;
    cpu_ack_next   = 1'b0;
    cpu_rdata_next = cpu_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (count_reg != 2'd0) begin
          state_next    = ACCESS;
          grant_dl_next = 1'b1;
          slot_next     = 4'd0;
          mem_addr_next = DL_BASE | {11'd0, head_addr};
          mem_din_next  = head_data;
          mem_we_next   = 1'b1;
          mem_oe_next   = 1'b0;
        end else if (cpu_req && !dl_active) begin
          state_next    = ACCESS;
          grant_dl_next = 1'b0;
          slot_next     = 4'd0;
          mem_addr_next = {9'd0, cpu_addr};
          mem_din_next  = cpu_wdata;
          mem_we_next   = cpu_we;
          mem_oe_next   = !cpu_we;
        end
      end
      ACCESS: begin
        if (slot_reg == LAST_SLOT) begin
          state_next  = DONE;
          mem_we_next = 1'b0;
          mem_oe_next = 1'b0;
          if (!grant_dl_reg) begin
            cpu_ack_next = 1'b1;
            if (mem_oe_reg) cpu_rdata_next = mem_dout;
          end
        end else begin
          slot_next = slot_reg + 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next  = IDLE;
        mem_we_next = 1'b0;
        mem_oe_next = 1'b0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // Download bookkeeping: overrun, seen-write and the sticky loaded flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_active_q_reg <= 1'b0;
      seen_write_reg  <= 1'b0;
      dl_overrun_reg  <= 1'b0;
      rom_loaded_reg  <= 1'b0;
    end else begin
      dl_active_q_reg <= dl_active;
      if (dl_wr)        seen_write_reg <= 1'b1;
      else if (dl_rise) seen_write_reg <= 1'b0;
      if (dl_wr && !fifo_accept) dl_overrun_reg <= 1'b1;
      else if (dl_rise)          dl_overrun_reg <= 1'b0;
      if (dl_rise)
        rom_loaded_reg <= 1'b0;
      else if (!dl_active && (count_reg == 2'd0) && (state_reg == IDLE) && seen_write_reg)
        rom_loaded_reg <= 1'b1;
    end
  end

  assign mem_addr   = mem_addr_reg;
  assign mem_din    = mem_din_reg;
  assign mem_we     = mem_we_reg;
  assign mem_oe     = mem_oe_reg;
  assign cpu_ack    = cpu_ack_reg;
  assign cpu_rdata  = cpu_rdata_reg;
  assign busy       = busy_reg;
  assign dl_overrun = dl_overrun_reg;
  assign rom_loaded = rom_loaded_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter with SLOT_CYCLES=4.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        dl_active, dl_wr;
  logic [13:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_overrun, rom_loaded;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we, mem_oe;
  logic [7:0]  mem_dout;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  sdram_port_arbiter #(.SLOT_CYCLES(4), .DL_BASE(25'h000C000)) dut (
    .clk(clk), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_overrun(dl_overrun), .rom_loaded(rom_loaded),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; sample/drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] dl_bytes [3];
  int acks;
  int waited;
  bit got_ack;

  initial begin
    dl_bytes[0] = 8'h11; dl_bytes[1] = 8'h22; dl_bytes[2] = 8'h33;
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; mem_dout = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset values
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_din", 32'(mem_din), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_oe", 32'(mem_oe), 32'h0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    check("rst_overrun", 32'(dl_overrun), 32'h0);
    check("rst_rom_loaded", 32'(rom_loaded), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // CPU read at 0x3800 returning A5
    cpu_addr = 16'h3800; cpu_we = 1'b0; mem_dout = 8'hA5; cpu_req = 1'b1;
    tick();
    check("rd_oe_grant", 32'(mem_oe), 32'h1);
    check("rd_we_grant", 32'(mem_we), 32'h0);
    check("rd_addr", 32'(mem_addr), 32'h0003800);
    check("rd_busy", 32'(busy), 32'h1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("rd_oe_slot%0d", i), 32'(mem_oe), 32'h1);
      check($sformatf("rd_noack_slot%0d", i), 32'(cpu_ack), 32'h0);
    end
    tick();
    check("rd_oe_done", 32'(mem_oe), 32'h0);
    check("rd_ack", 32'(cpu_ack), 32'h1);
    check("rd_rdata", 32'(cpu_rdata), 32'hA5);
    cpu_req = 1'b0;
    tick();
    check("rd_ack_single", 32'(cpu_ack), 32'h0);
    check("rd_busy_idle", 32'(busy), 32'h0);
    mem_dout = 8'h00;
    tick();
    check("rd_rdata_hold", 32'(cpu_rdata), 32'hA5);

    // Download of three bytes, strobes 8 cycles apart
    dl_active = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      dl_addr = 14'(b); dl_data = dl_bytes[b]; dl_wr = 1'b1;
      tick();
      dl_wr = 1'b0;
      if (b == 2) dl_active = 1'b0;
      tick();
      check($sformatf("dl%0d_we", b), 32'(mem_we), 32'h1);
      check($sformatf("dl%0d_addr", b), 32'(mem_addr), 32'h000C000 + 32'(b));
      check($sformatf("dl%0d_din", b), 32'(mem_din), 32'(dl_bytes[b]));
      tick(); tick(); tick();
      check($sformatf("dl%0d_we_last", b), 32'(mem_we), 32'h1);
      tick();
      check($sformatf("dl%0d_we_done", b), 32'(mem_we), 32'h0);
      if (b < 2) begin
        check($sformatf("dl%0d_not_loaded", b), 32'(rom_loaded), 32'h0);
        tick(); tick();
      end
    end
    check("dl_loaded_in_done", 32'(rom_loaded), 32'h0);
    tick(); tick();
    check("dl_rom_loaded", 32'(rom_loaded), 32'h1);
    check("dl_no_overrun", 32'(dl_overrun), 32'h0);

    // Overrun: three strobes during a CPU write slot
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h77;
    tick();
    check("wr_we", 32'(mem_we), 32'h1);
    check("wr_oe", 32'(mem_oe), 32'h0);
    check("wr_addr", 32'(mem_addr), 32'h0001234);
    check("wr_din", 32'(mem_din), 32'h77);
    dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 14'd6; dl_data = 8'h66;
    tick();
    check("ov_loaded_cleared", 32'(rom_loaded), 32'h0);
    dl_addr = 14'd7; dl_data = 8'h77;
    tick();
    check("ov_not_yet", 32'(dl_overrun), 32'h0);
    dl_addr = 14'd8; dl_data = 8'h88;
    tick();
    check("ov_set", 32'(dl_overrun), 32'h1);
    dl_wr = 1'b0;
    tick();
    check("wr_ack", 32'(cpu_ack), 32'h1);
    cpu_req = 1'b0;
    tick();
    tick();
    check("ov_drain0_addr", 32'(mem_addr), 32'h000C006);
    check("ov_drain0_din", 32'(mem_din), 32'h66);
    for (int i = 0; i < 6; i++) tick();
    check("ov_drain1_addr", 32'(mem_addr), 32'h000C007);
    check("ov_drain1_din", 32'(mem_din), 32'h77);
    for (int i = 0; i < 6; i++) tick();
    check("ov_third_dropped_we", 32'(mem_we), 32'h0);
    check("ov_third_dropped_busy", 32'(busy), 32'h0);
    check("ov_sticky", 32'(dl_overrun), 32'h1);
    dl_active = 1'b0;
    tick();
    dl_active = 1'b1;
    tick();
    check("ov_cleared_by_rise", 32'(dl_overrun), 32'h0);

    // Same-cycle cpu_req and dl_wr while downloading: DL wins
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042; mem_dout = 8'h5A;
    dl_wr = 1'b1; dl_addr = 14'd9; dl_data = 8'h99;
    tick();
    dl_wr = 1'b0;
    check("pri_no_grant_yet", 32'(busy), 32'h0);
    tick();
    check("pri_dl_we", 32'(mem_we), 32'h1);
    check("pri_dl_addr", 32'(mem_addr), 32'h000C009);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    check("pri_cpu_blocked", 32'(acks), 32'h0);
    dl_active = 1'b0;
    got_ack = 1'b0;
    waited = 0;
    for (int i = 0; i < 20 && !got_ack; i++) begin
      tick();
      waited++;
      if (cpu_ack) got_ack = 1'b1;
    end
    check("pri_cpu_ack", 32'(got_ack), 32'h1);
    check("pri_cpu_latency", 32'(waited), 32'd5);
    check("pri_cpu_rdata", 32'(cpu_rdata), 32'h5A);
    cpu_req = 1'b0;
    tick();

    // Reset during slot 2 of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'hEE;
    tick(); tick(); tick();
    check("rs_we_before", 32'(mem_we), 32'h1);
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    check("rs_we_async", 32'(mem_we), 32'h0);
    check("rs_addr", 32'(mem_addr), 32'h0);
    check("rs_din", 32'(mem_din), 32'h0);
    check("rs_busy", 32'(busy), 32'h0);
    check("rs_rdata", 32'(cpu_rdata), 32'h0);
    check("rs_rom_loaded", 32'(rom_loaded), 32'h0);
    tick();
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    check("rs_no_ack", 32'(acks), 32'h0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200; mem_dout = 8'h3C;
    tick();
    check("rs_next_oe", 32'(mem_oe), 32'h1);
    check("rs_next_addr", 32'(mem_addr), 32'h0000200);
    got_ack = 1'b0;
    waited = 0;
    for (int i = 0; i < 10 && !got_ack; i++) begin
      tick();
      waited++;
      if (cpu_ack) got_ack = 1'b1;
    end
    check("rs_next_ack", 32'(got_ack), 32'h1);
    check("rs_next_latency", 32'(waited), 32'd4);
    check("rs_next_rdata", 32'(cpu_rdata), 32'h3C);
    cpu_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
